// File: rtl/ranger_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ranger_pkg
// Description : Shared FSM state type and 50 MHz default timings for the
//               ultrasonic ranger.
// Revision    : 1.0 - initial release
// ============================================================================
package ranger_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TRIG    = 3'd1,
        S_WAIT    = 3'd2,
        S_MEASURE = 3'd3,
        S_HOLDOFF = 3'd4
    } state_t;

    localparam int          DEF_CNT_W       = 32;
    localparam int unsigned DEF_TRIG_CYC    = 500;
    localparam int unsigned DEF_WAIT_MAX    = 1_500_000;
    localparam int unsigned DEF_ECHO_MAX    = 1_900_000;
    localparam int unsigned DEF_HOLDOFF_CYC = 2_500_000;
    localparam int          DEF_FILT_CYC    = 4;

    // True when v is representable in an unsigned field of w bits.
    function automatic bit fits_width(input longint unsigned v, input int w);
        return (w >= 64) || ((v >> w) == 64'd0);
    endfunction

endpackage : ranger_pkg
`default_nettype wire

// File: rtl/echo_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : echo_conditioner
// Description : Two-flop synchroniser for the raw echo pin, plus an optional
//               FILT_CYC-cycle deglitch filter enabled by RANGER_FILTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module echo_conditioner #(
    parameter int FILT_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic echo,
    output logic echo_f
);

    logic sync_1;
    logic echo_s;

    if (FILT_CYC < 1) begin : g_filt_check
        $error("echo_conditioner: FILT_CYC must be at least 1");
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            echo_s <= 1'b0;
        end else begin
            sync_1 <= echo;
            echo_s <= sync_1;
        end
    end

`ifdef RANGER_FILTER_EN
    localparam int FW = $clog2(FILT_CYC + 1);

    logic [FW-1:0] filt_cnt;
    logic          filt;

    // Both edges need FILT_CYC disagreeing samples, so pulse width is preserved.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_cnt <= '0;
            filt     <= 1'b0;
        end else if (echo_s != filt) begin
            if (filt_cnt == FW'(FILT_CYC - 1)) begin
                filt     <= echo_s;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end else begin
            filt_cnt <= '0;
        end
    end

    assign echo_f = filt;
`else
    assign echo_f = echo_s;
`endif

endmodule : echo_conditioner
`default_nettype wire

// File: rtl/ultrasonic_ranger.sv
`default_nettype none
// ============================================================================
// Module      : ultrasonic_ranger
// Description : HC-SR04-class range controller: trigger generation, echo
//               width measurement, timeouts and hold-off. RANGER_FILTER_EN
//               enables the echo deglitch filter.
// Revision    : 1.0 - initial release
// ============================================================================
module ultrasonic_ranger
    import ranger_pkg::*;
#(
    parameter int          CNT_W       = DEF_CNT_W,
    parameter int unsigned TRIG_CYC    = DEF_TRIG_CYC,
    parameter int unsigned WAIT_MAX    = DEF_WAIT_MAX,
    parameter int unsigned ECHO_MAX    = DEF_ECHO_MAX,
    parameter int unsigned HOLDOFF_CYC = DEF_HOLDOFF_CYC,
    parameter int          FILT_CYC    = DEF_FILT_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cont,
    input  logic             echo,
    output logic             trigger,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] distance,
    output logic             timeout
);

    if (!fits_width(TRIG_CYC, CNT_W) || !fits_width(WAIT_MAX, CNT_W) ||
        !fits_width(ECHO_MAX, CNT_W) || !fits_width(HOLDOFF_CYC, CNT_W) ||
        TRIG_CYC == 0 || WAIT_MAX == 0 || ECHO_MAX == 0 || HOLDOFF_CYC == 0)
    begin : g_param_check
        $error("ultrasonic_ranger: timing parameter zero or too wide for CNT_W");
    end

    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);
    localparam logic [CNT_W-1:0] ECHO_LAST = CNT_W'(ECHO_MAX - 1);
    localparam logic [CNT_W-1:0] ECHO_SAT  = CNT_W'(ECHO_MAX);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYC - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             echo_f;
    logic             echo_prev;

    echo_conditioner #(
        .FILT_CYC (FILT_CYC)
    ) u_echo_conditioner (
        .clk    (clk),
        .rst_n  (rst_n),
        .echo   (echo),
        .echo_f (echo_f)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            trigger   <= 1'b0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            distance  <= '0;
            timeout   <= 1'b0;
            echo_prev <= 1'b0;
        end else begin
            echo_prev <= echo_f;
            valid     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start || cont) begin
                        state   <= S_TRIG;
                        cnt     <= '0;
                        trigger <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                S_TRIG: begin
                    if (cnt == TRIG_LAST) begin
                        state   <= S_WAIT;
                        cnt     <= '0;
                        trigger <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    // Edge-qualified so an echo already high on entry is ignored.
                    if (echo_f && !echo_prev) begin
                        state <= S_MEASURE;
                        cnt   <= CNT_W'(1);
                    end else if (cnt == WAIT_LAST) begin
                        state    <= S_HOLDOFF;
                        cnt      <= '0;
                        valid    <= 1'b1;
                        distance <= '0;
                        timeout  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_MEASURE: begin
                    if (!echo_f) begin
                        state    <= S_HOLDOFF;
                        cnt      <= '0;
                        valid    <= 1'b1;
                        distance <= cnt;
                        timeout  <= 1'b0;
                    end else if (cnt == ECHO_LAST) begin
                        state    <= S_HOLDOFF;
                        cnt      <= '0;
                        valid    <= 1'b1;
                        distance <= ECHO_SAT;
                        timeout  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_HOLDOFF: begin
                    if (cnt == HOLD_LAST) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    cnt     <= '0;
                    trigger <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule : ultrasonic_ranger
`default_nettype wire

// File: tb/tb_ultrasonic_ranger.sv
`default_nettype none
// ============================================================================
// Module      : tb_ultrasonic_ranger
// Description : Self-checking bench for ultrasonic_ranger; honours
//               RANGER_FILTER_EN when expecting glitch rejection.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ultrasonic_ranger;

    localparam int CNT_W       = 16;
    localparam int TRIG_CYC    = 10;
    localparam int WAIT_MAX    = 100;
    localparam int ECHO_MAX    = 200;
    localparam int HOLDOFF_CYC = 50;
    localparam int FILT_CYC    = 4;
`ifdef RANGER_FILTER_EN
    localparam int MIN_W = FILT_CYC;
`else
    localparam int MIN_W = 1;
`endif

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             cont  = 1'b0;
    logic             echo  = 1'b0;
    logic             trigger, busy, valid, timeout;
    logic [CNT_W-1:0] distance;

    int checks = 0, errors = 0, cyc = 0, last_valid = -1;

    always #10 clk = ~clk;

    ultrasonic_ranger #(
        .CNT_W       (CNT_W),
        .TRIG_CYC    (TRIG_CYC),
        .WAIT_MAX    (WAIT_MAX),
        .ECHO_MAX    (ECHO_MAX),
        .HOLDOFF_CYC (HOLDOFF_CYC),
        .FILT_CYC    (FILT_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cont     (cont),
        .echo     (echo),
        .trigger  (trigger),
        .busy     (busy),
        .valid    (valid),
        .distance (distance),
        .timeout  (timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Result of a shot: the first pulse that starts inside WAIT and survives the
    // filter is measured; no such pulse means a no-echo timeout.
    function automatic void model(input int a0, input int aw, input int b0, input int bw,
                                  output int d, output bit t);
        int st[2];
        int wd[2];
        st[0] = a0; st[1] = b0; wd[0] = aw; wd[1] = bw;
        d = 0;
        t = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (st[k] >= 0 && wd[k] >= MIN_W) begin
                if (wd[k] >= ECHO_MAX) begin
                    d = ECHO_MAX;
                    t = 1'b1;
                end else begin
                    d = wd[k];
                    t = 1'b0;
                end
                return;
            end
        end
    endfunction

    // a0 < 0 means echo is already high during the trigger and stays for aw cycles.
    function automatic bit in_pulse(input int i, input int a0, input int aw,
                                    input int b0, input int bw);
        bit pa;
        pa = (a0 < 0) ? (i < aw) : (i >= a0 && i < a0 + aw);
        return pa || (i >= b0 && i < b0 + bw);
    endfunction

    task automatic shot(input int a0, input int aw, input int b0, input int bw, input int ms,
                        input bit pulse_start, input bit cont_mode, input bit chk_gap,
                        input string tag);
        int exp_d, t_fall, t_valid, nvalid, extra_trig, n, endi;
        bit exp_t;
        logic [CNT_W-1:0] got_d;
        logic got_t;
        model(a0, aw, b0, bw, exp_d, exp_t);
        endi = (a0 < 0) ? aw : a0 + aw;
        if (b0 + bw > endi) endi = b0 + bw;
        if (pulse_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        n = 0;
        while (trigger !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, ".trig_rise"}, trigger, 1);
        if (chk_gap) check({tag, ".retrig_gap"}, cyc - last_valid, HOLDOFF_CYC + 1);
        if (a0 < 0) echo = 1'b1;
        n = 0;
        while (trigger === 1'b1 && n < TRIG_CYC + 5) begin
            tick();
            n++;
        end
        check({tag, ".trig_len"}, n, TRIG_CYC);
        t_fall = cyc; t_valid = -1; nvalid = 0; extra_trig = 0; got_d = '0; got_t = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            echo  = in_pulse(i, a0, aw, b0, bw);
            start = (i == ms);
            tick();
            if (valid === 1'b1) begin
                nvalid++;
                if (t_valid < 0) begin
                    t_valid = cyc;
                    got_d   = distance;
                    got_t   = timeout;
                end
            end
            if (t_valid >= 0) begin
                if (cyc - t_valid == HOLDOFF_CYC - 1) check({tag, ".busy_hold"}, busy, 1);
                if (cyc - t_valid == HOLDOFF_CYC)     check({tag, ".busy_idle"}, busy, 0);
                if (cyc - t_valid > HOLDOFF_CYC) begin
                    if (cont_mode) begin
                        check({tag, ".cont_trig"}, trigger, 1);
                        break;
                    end
                    if (trigger === 1'b1) extra_trig++;
                    if (i >= endi + 5) break;
                end
            end
        end
        start = 1'b0;
        echo  = 1'b0;
        check({tag, ".valid_count"}, nvalid, 1);
        check({tag, ".distance"}, got_d, exp_d);
        check({tag, ".timeout"}, got_t, exp_t);
        if (exp_t && exp_d == 0) check({tag, ".wait_len"}, t_valid - t_fall, WAIT_MAX);
        if (!cont_mode) check({tag, ".no_retrig"}, extra_trig, 0);
        last_valid = t_valid;
    endtask

    initial begin
        int n, nv, d, w, kind;
        repeat (3) tick();
        check("rst.trigger", trigger, 0);
        check("rst.busy", busy, 0);
        check("rst.valid", valid, 0);
        check("rst.distance", distance, 0);
        check("rst.timeout", timeout, 0);
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle.busy", busy, 0);

        shot(20, 37, 0, 0, -1, 1'b1, 1'b0, 1'b0, "normal");
        shot(0, 0, 0, 0, -1, 1'b1, 1'b0, 1'b0, "no_echo");
        shot(15, 300, 0, 0, -1, 1'b1, 1'b0, 1'b0, "over_range");

        for (int k = 0; k < 4; k++) begin
            kind = int'($urandom_range(0, 3));
            d    = int'($urandom_range(0, 60));
            case (kind)
                0:       w = 0;
                1:       w = int'($urandom_range(250, 300));
                default: w = int'($urandom_range(1, 150));
            endcase
            shot(d, w, 0, 0, d + w / 2, 1'b1, 1'b0, 1'b0, "rand_single");
        end

        cont = 1'b1;
        for (int k = 0; k < 3; k++) begin
            d = int'($urandom_range(0, 40));
            w = int'($urandom_range(20, 120));
            shot(d, w, 0, 0, d + w / 2, 1'b0, 1'b1, (k != 0), "cont");
        end
        cont = 1'b0;
        d = int'($urandom_range(0, 40));
        w = int'($urandom_range(20, 120));
        shot(d, w, 0, 0, -1, 1'b0, 1'b0, 1'b1, "cont_stop");

        shot(-1, 30, 45, 37, -1, 1'b1, 1'b0, 1'b0, "stale");

        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (trigger === 1'b1 && n < TRIG_CYC + 5) begin
            tick();
            n++;
        end
        echo = 1'b1;
        nv = 0;
        repeat (20) begin
            tick();
            if (valid === 1'b1) nv++;
        end
        check("abort.busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort.trigger", trigger, 0);
        check("abort.busy", busy, 0);
        check("abort.valid", valid, 0);
        check("abort.distance", distance, 0);
        check("abort.timeout", timeout, 0);
        check("abort.no_valid", nv, 0);
        echo = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        nv = 0;
        repeat (5) begin
            tick();
            if (valid === 1'b1) nv++;
        end
        check("abort.idle_after", busy, 0);
        check("abort.quiet_after", nv, 0);

        shot(5, 2, 40, 37, -1, 1'b1, 1'b0, 1'b0, "glitch");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ultrasonic_ranger
`default_nettype wire
